// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU dispatch slice: op codes, unit indices,
// per-unit channel usage masks and the dispatcher state type.
package fpu_pkg;

    localparam int unsigned N_UNITS = 9;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_DIV  = 4'd3;
    localparam logic [3:0] OP_SQRT = 4'd4;
    localparam logic [3:0] OP_ABS  = 4'd5;
    localparam logic [3:0] OP_CMP  = 4'd6;
    localparam logic [3:0] OP_FTOI = 4'd7;
    localparam logic [3:0] OP_ITOF = 4'd8;

    localparam int unsigned UNIT_FADD  = 0;
    localparam int unsigned UNIT_FSUB  = 1;
    localparam int unsigned UNIT_FMUL  = 2;
    localparam int unsigned UNIT_FDIV  = 3;
    localparam int unsigned UNIT_FSQRT = 4;
    localparam int unsigned UNIT_FABS  = 5;
    localparam int unsigned UNIT_FCMP  = 6;
    localparam int unsigned UNIT_FTOI  = 7;
    localparam int unsigned UNIT_FITOF = 8;

    // Op code doubles as unit index, so these masks are indexed by either.
    localparam logic [N_UNITS-1:0] USES_B  = 9'b0_0100_1111;
    localparam logic [N_UNITS-1:0] USES_OP = 9'b0_0100_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    function automatic logic [N_UNITS-1:0] unit_onehot(input logic [3:0] idx);
        return N_UNITS'(1) << idx;
    endfunction

endpackage

// File: rtl/fpu_res_mux.sv
// Result selector: picks the selected unit's 32-bit result slice; the
// compare unit only produces 8 bits, which are zero-extended.
import fpu_pkg::*;

module fpu_res_mux (
    input  logic [32*N_UNITS-1:0] u_res,
    input  logic [3:0]            sel,
    output logic [31:0]           res
);

    always_comb begin
        res = '0;
        for (int unsigned i = 0; i < N_UNITS; i++) begin
            if (32'(sel) == i) begin
                res = u_res[32*i +: 32];
            end
        end
        if (sel == 4'(UNIT_FCMP)) begin
            res = {24'd0, u_res[32*UNIT_FCMP +: 8]};
        end
    end

endmodule

// File: rtl/fpu_dispatch.sv
// Single-issue dispatcher between the FP execute stage and the nine FPU units,
// with per-channel operand handshakes, result capture and a hang watchdog.
import fpu_pkg::*;

module fpu_dispatch #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [3:0]             req_op,
    input  logic [31:0]            req_a,
    input  logic [31:0]            req_b,
    input  logic [7:0]             req_cmpop,
    output logic [31:0]            u_opa,
    output logic [31:0]            u_opb,
    output logic [7:0]             u_cmpop,
    output logic [N_UNITS-1:0]     u_valid_a,
    input  logic [N_UNITS-1:0]     u_ready_a,
    output logic [N_UNITS-1:0]     u_valid_b,
    input  logic [N_UNITS-1:0]     u_ready_b,
    output logic                   u_valid_op,
    input  logic                   u_ready_op,
    input  logic [N_UNITS-1:0]     u_out_valid,
    input  logic [32*N_UNITS-1:0]  u_res,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [31:0]            rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [CNT_W-1:0]       done_cnt
);

    localparam int unsigned    WD_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam bit             WD_EN   = (TIMEOUT_CYC != 0);

    state_t               state, state_nx;
    logic [3:0]           sel;
    logic                 done_a, done_b, done_op;
    logic [WD_W-1:0]      wd_cnt;
    logic [N_UNITS-1:0]   sel_oh, req_oh;
    logic                 req_legal;
    logic                 va_on, vb_on, vop_on;
    logic                 ack_a, ack_b, ack_op, all_done, out_hit;
    logic                 do_accept, do_reject, do_capture, do_timeout, do_retire;
    logic [31:0]          mux_res;

    fpu_res_mux u_res_mux (
        .u_res (u_res),
        .sel   (sel),
        .res   (mux_res)
    );

    assign sel_oh    = unit_onehot(sel);
    assign req_oh    = unit_onehot(req_op);
    assign req_legal = (req_op < 4'(N_UNITS));

    assign va_on  = (state == ST_ISSUE) && !done_a;
    assign vb_on  = (state == ST_ISSUE) && !done_b;
    assign vop_on = (state == ST_ISSUE) && !done_op;

    assign u_valid_a  = va_on ? sel_oh : '0;
    assign u_valid_b  = vb_on ? (sel_oh & USES_B) : '0;
    assign u_valid_op = vop_on;

    assign ack_a    = va_on  && |(u_ready_a & sel_oh);
    assign ack_b    = vb_on  && |(u_ready_b & sel_oh);
    assign ack_op   = vop_on && u_ready_op;
    // A channel acknowledged at this edge counts as done for the ISSUE exit.
    assign all_done = (done_a | ack_a) & (done_b | ack_b) & (done_op | ack_op);
    assign out_hit  = |(u_out_valid & sel_oh);

    assign req_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

    always_comb begin
        state_nx   = state;
        do_accept  = 1'b0;
        do_reject  = 1'b0;
        do_capture = 1'b0;
        do_timeout = 1'b0;
        do_retire  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_legal) begin
                        do_accept = 1'b1;
                        state_nx  = ST_ISSUE;
                    end else begin
                        do_reject = 1'b1;
                        state_nx  = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                if (all_done) begin
                    if (out_hit) begin
                        do_capture = 1'b1;
                        state_nx   = ST_RESP;
                    end else begin
                        state_nx   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (out_hit) begin
                    do_capture = 1'b1;
                    state_nx   = ST_RESP;
                end else if (WD_EN && (wd_cnt == WD_LAST)) begin
                    do_timeout = 1'b1;
                    state_nx   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    do_retire = 1'b1;
                    state_nx  = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            sel      <= '0;
            u_opa    <= '0;
            u_opb    <= '0;
            u_cmpop  <= '0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            done_op  <= 1'b0;
            wd_cnt   <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
            done_cnt <= '0;
        end else begin
            state <= state_nx;

            if (do_accept) begin
                sel     <= req_op;
                u_opa   <= req_a;
                u_opb   <= req_b;
                u_cmpop <= req_cmpop;
                done_a  <= 1'b0;
                done_b  <= ~|(req_oh & USES_B);
                done_op <= ~|(req_oh & USES_OP);
            end else begin
                if (ack_a)  done_a  <= 1'b1;
                if (ack_b)  done_b  <= 1'b1;
                if (ack_op) done_op <= 1'b1;
            end

            wd_cnt <= ((state == ST_WAIT) && (state_nx == ST_WAIT)) ? wd_cnt + 1'b1 : '0;

            if (do_capture) begin
                rsp_data <= mux_res;
                rsp_err  <= 1'b0;
            end else if (do_reject || do_timeout) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end

            if (do_retire && !rsp_err) begin
                done_cnt <= done_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch: a scripted unit responder, a transaction-level
// expectation model and a per-cycle compare process.
module tb_fpu_dispatch;

    localparam int unsigned TO = 8;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_op = '0;
    logic [31:0]  req_a = '0;
    logic [31:0]  req_b = '0;
    logic [7:0]   req_cmpop = '0;
    logic [31:0]  u_opa, u_opb;
    logic [7:0]   u_cmpop;
    logic [8:0]   u_valid_a, u_valid_b;
    logic [8:0]   u_ready_a = '0;
    logic [8:0]   u_ready_b = '0;
    logic         u_valid_op;
    logic         u_ready_op = 1'b0;
    logic [8:0]   u_out_valid = '0;
    logic [287:0] u_res = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [31:0]  rsp_data;
    logic         rsp_err;
    logic         busy;
    logic [31:0]  done_cnt;

    always #5 clk = ~clk;

    fpu_dispatch #(.TIMEOUT_CYC(TO), .CNT_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cmpop(req_cmpop),
        .u_opa(u_opa), .u_opb(u_opb), .u_cmpop(u_cmpop),
        .u_valid_a(u_valid_a), .u_ready_a(u_ready_a),
        .u_valid_b(u_valid_b), .u_ready_b(u_ready_b),
        .u_valid_op(u_valid_op), .u_ready_op(u_ready_op),
        .u_out_valid(u_out_valid), .u_res(u_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .done_cnt(done_cnt)
    );

    // Responder script for the current transaction
    int unsigned txn_id = 0;
    logic [3:0]  c_unit = '0;
    int unsigned c_da = 0, c_db = 0, c_dop = 0, c_lat = 0;
    logic [31:0] c_res = '0;
    bit          c_hang = 0, c_noise = 0, c_needb = 0, c_needop = 0;
    logic [8:0]  extra_ov = '0;

    // Expectation model
    bit          m_inflight = 0;
    logic [3:0]  m_op = '0;
    logic [31:0] m_opa = '0, m_opb = '0, m_cnt = '0;
    logic [7:0]  m_cmp = '0;

    int unsigned n_chk = 0, n_pass = 0;
    int unsigned va_cyc = 0, vb_cyc = 0, vop_cyc = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    function automatic bit uses_b(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd3) || (op == 4'd6);
    endfunction

    // Unit responder: raises ready after c_d* valid cycles, pulses result c_lat cycles after last ready.
    int unsigned r_id = 0, r_ca = 0, r_cb = 0, r_cop = 0, r_wc = 0;
    bit          r_da = 0, r_db = 0, r_dop = 0, r_pend = 0, r_fired = 0;
    always begin : responder
        int ui, ni;
        @(negedge clk);
        #1;
        if (txn_id != r_id) begin
            r_id = txn_id;
            r_da = 0; r_db = !c_needb; r_dop = !c_needop;
            r_ca = 0; r_cb = 0; r_cop = 0;
            r_pend = 0; r_fired = 0;
        end
        u_ready_a   = '0;
        u_ready_b   = '0;
        u_ready_op  = 1'b0;
        u_out_valid = extra_ov;
        for (int i = 0; i < 9; i++) u_res[32*i +: 32] = 32'hA5A5_0000 | 32'(i);
        if (c_unit < 4'd9) begin
            ui = int'(c_unit);
            if (!r_da && u_valid_a[ui]) begin
                if (r_ca >= c_da) begin u_ready_a[ui] = 1'b1; r_da = 1; end
                else r_ca++;
            end
            if (!r_db && u_valid_b[ui]) begin
                if (r_cb >= c_db) begin u_ready_b[ui] = 1'b1; r_db = 1; end
                else r_cb++;
            end
            if (!r_dop && u_valid_op) begin
                if (r_cop >= c_dop) begin u_ready_op = 1'b1; r_dop = 1; end
                else r_cop++;
            end
            if (r_da && r_db && r_dop && !r_pend && !r_fired) begin
                r_pend = 1;
                r_wc = c_lat;
            end
            if (r_pend && !c_hang) begin
                if (r_wc == 0) begin
                    u_out_valid[ui] = 1'b1;
                    u_res[32*ui +: 32] = c_res;
                    r_pend = 0;
                    r_fired = 1;
                end else begin
                    r_wc--;
                end
            end
            if (c_noise) begin
                ni = (ui + 1) % 9;
                u_out_valid[ni] = 1'b1;
                u_res[32*ni +: 32] = 32'hDEADBEEF;
            end
        end
    end

    // Per-cycle compare, sampled 2 time units after each rising edge.
    int unsigned k_id = 0;
    logic        p_v = 1'b0, p_e = 1'b0;
    logic [31:0] p_d = '0;
    always begin : compare
        logic [8:0] allowed;
        @(posedge clk);
        #2;
        if (txn_id != k_id) begin
            k_id = txn_id;
            va_cyc = 0; vb_cyc = 0; vop_cyc = 0;
        end
        if (u_valid_a != '0) va_cyc++;
        if (u_valid_b != '0) vb_cyc++;
        if (u_valid_op) vop_cyc++;
        allowed = m_inflight ? (9'(1) << m_op) : '0;
        check("onehot_a", 32'($countones(u_valid_a) <= 1), 32'd1);
        check("onehot_b", 32'($countones(u_valid_b) <= 1), 32'd1);
        check("mask_a", 32'(u_valid_a & ~allowed), 32'd0);
        check("mask_b", 32'(u_valid_b & ~(uses_b(m_op) ? allowed : 9'd0)), 32'd0);
        check("mask_op", 32'(u_valid_op && !(m_inflight && m_op == 4'd6)), 32'd0);
        check("busy_vs_ready", 32'(busy), 32'(!req_ready));
        check("done_cnt", done_cnt, m_cnt);
        check("opa", u_opa, m_opa);
        check("opb", u_opb, m_opb);
        check("cmpop", 32'(u_cmpop), 32'(m_cmp));
        if (p_v && rstn && !rsp_ready) begin
            check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
            check("rsp_hold_data", rsp_data, p_d);
            check("rsp_hold_err", 32'(rsp_err), 32'(p_e));
        end
        p_v = rsp_valid; p_d = rsp_data; p_e = rsp_err;
    end

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [7:0] cmp, input int unsigned da, input int unsigned db,
                         input int unsigned dop, input int unsigned lat, input logic [31:0] res,
                         input bit hang, input bit noise, input int unsigned hold, input bit late,
                         output logic [31:0] d, output logic e, output int unsigned n);
        bit          legal, nb, nop, exp_err;
        int unsigned k, dmax, exp_n;
        logic [31:0] exp_d;
        legal = (op < 4'd9);
        nb    = legal && uses_b(op);
        nop   = legal && (op == 4'd6);
        exp_err = !legal || hang;
        exp_d   = exp_err ? 32'd0 : (nop ? {24'd0, res[7:0]} : res);
        dmax = da;
        if (nb && db > dmax) dmax = db;
        if (nop && dop > dmax) dmax = dop;
        exp_n = !legal ? 1 : 2 + dmax + (hang ? TO : lat);

        k = 0;
        while (!req_ready && k < 50) begin @(negedge clk); k++; end
        check("req_ready_wait", 32'(req_ready), 32'd1);

        txn_id++;
        c_unit = op; c_da = da; c_db = db; c_dop = dop; c_lat = lat; c_res = res;
        c_hang = hang; c_noise = noise; c_needb = nb; c_needop = nop;
        m_inflight = legal;
        if (legal) begin
            m_op = op; m_opa = a; m_opb = b; m_cmp = cmp;
        end
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cmpop = cmp;
        @(negedge clk);
        req_valid = 1'b0;

        n = 1;
        while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
        d = rsp_data;
        e = rsp_err;
        check("latency", n, exp_n);
        check("rsp_data", d, exp_d);
        check("rsp_err", 32'(e), 32'(exp_err));
        check("valid_a_cycles", va_cyc, legal ? da + 1 : 0);
        check("valid_b_cycles", vb_cyc, nb ? db + 1 : 0);
        check("valid_op_cycles", vop_cyc, nop ? dop + 1 : 0);

        if (late) extra_ov = '1;
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            extra_ov = '0;
        end
        rsp_ready = 1'b1;
        if (!exp_err) m_cnt++;
        m_inflight = 0;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_after_rsp", 32'(busy), 32'd0);
    endtask

    initial begin : main
        logic [31:0] d;
        logic        e;
        int unsigned n;

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_valids", 32'({u_valid_a, u_valid_b, u_valid_op}), 32'd0);
        check("rst_done_cnt", done_cnt, 32'd0);
        rstn = 1'b1;

        // fadd, unit latency 3, noise on a neighbouring unit's out_valid
        do_op(4'd0, 32'h3F80_0000, 32'h4000_0000, 8'h00, 0, 0, 0, 3, 32'h4040_0000, 0, 1, 0, 0, d, e, n);
        check("t1_data", d, 32'h4040_0000);
        check("t1_err", 32'(e), 32'd0);
        check("t1_lat", n, 32'd5);
        check("t1_cnt", done_cnt, 32'd1);

        // fmul with operand b stalled 4 cycles, response held 3 cycles
        do_op(4'd2, 32'h4000_0000, 32'h4040_0000, 8'h00, 0, 4, 0, 1, 32'h40C0_0000, 0, 0, 3, 0, d, e, n);
        check("t2_data", d, 32'h40C0_0000);
        check("t2_vb", vb_cyc, 32'd5);
        check("t2_va", va_cyc, 32'd1);

        // fcmp: result upper bits are junk and must be zeroed
        do_op(4'd6, 32'h3F80_0000, 32'h4000_0000, 8'h02, 1, 0, 2, 0, 32'hFFFF_FF01, 0, 0, 0, 0, d, e, n);
        check("t3_data", d, 32'h0000_0001);
        check("t3_vop", vop_cyc, 32'd3);

        // fsqrt: no operand b
        do_op(4'd4, 32'h4080_0000, 32'h1234_5678, 8'h00, 0, 0, 0, 2, 32'h4000_0000, 0, 0, 0, 0, d, e, n);
        check("t3b_data", d, 32'h4000_0000);
        check("t3b_vb", vb_cyc, 32'd0);

        // illegal op code
        do_op(4'hC, 32'h1111_1111, 32'h2222_2222, 8'h33, 0, 0, 0, 0, 32'h0, 0, 0, 1, 0, d, e, n);
        check("t4_err", 32'(e), 32'd1);
        check("t4_data", d, 32'd0);
        check("t4_lat", n, 32'd1);
        check("t4_cnt", done_cnt, 32'd4);

        // fdiv hangs: watchdog response, stray out_valid during RESP and IDLE
        do_op(4'd3, 32'h4120_0000, 32'h4000_0000, 8'h00, 0, 1, 0, 0, 32'h0, 1, 0, 2, 1, d, e, n);
        check("t5_err", 32'(e), 32'd1);
        check("t5_data", d, 32'd0);
        check("t5_lat", n, 32'd11);
        extra_ov = '1;
        @(negedge clk);
        extra_ov = '0;
        check("t5_late_busy", 32'(busy), 32'd0);
        check("t5_late_rsp", 32'(rsp_valid), 32'd0);
        check("t5_cnt", done_cnt, 32'd4);

        // reset while an op is waiting on a hung unit
        txn_id++;
        c_unit = 4'd3; c_da = 0; c_db = 0; c_dop = 0; c_lat = 0; c_res = '0;
        c_hang = 1; c_noise = 0; c_needb = 1; c_needop = 0;
        m_inflight = 1; m_op = 4'd3; m_opa = 32'h4110_0000; m_opb = 32'h4040_0000; m_cmp = 8'h5A;
        req_valid = 1'b1; req_op = 4'd3; req_a = m_opa; req_b = m_opb; req_cmpop = m_cmp;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t6_busy_wait", 32'(busy), 32'd1);
        rstn = 1'b0;
        m_inflight = 0; m_op = '0; m_opa = '0; m_opb = '0; m_cmp = '0; m_cnt = '0;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
        check("t6_data", rsp_data, 32'd0);
        check("t6_ops", u_opa | u_opb | 32'(u_cmpop), 32'd0);
        check("t6_valids", 32'({u_valid_a, u_valid_b, u_valid_op}), 32'd0);
        check("t6_cnt", done_cnt, 32'd0);
        rstn = 1'b1;
        extra_ov = '1;
        @(negedge clk);
        extra_ov = '0;
        check("t6_late_busy", 32'(busy), 32'd0);
        check("t6_late_rsp", 32'(rsp_valid), 32'd0);

        // fsub after reset with a zero-latency unit
        do_op(4'd1, 32'h4040_0000, 32'h3F80_0000, 8'h00, 0, 0, 0, 0, 32'h4000_0000, 0, 0, 0, 0, d, e, n);
        check("t7_data", d, 32'h4000_0000);
        check("t7_lat", n, 32'd2);
        check("t7_cnt", done_cnt, 32'd1);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin : guard
        #200000;
        $display("FAIL global_timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "time limit");
    end

endmodule
